// File: rtl/stp_word_sr.sv
// Serial-to-parallel word assembler: shifts bits into a live register and hands
// each completed NUM_BITS word to a consumer through a valid/ready holding register.
module stp_word_sr #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1'b1
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        clear,
    input  logic                        shift_enable,
    input  logic                        serial_in,
    output logic [NUM_BITS-1:0]         parallel_out,
    output logic [$clog2(NUM_BITS)-1:0] bit_count,
    output logic [NUM_BITS-1:0]         word_out,
    output logic                        word_valid,
    input  logic                        word_ready,
    output logic                        overflow
);

    localparam int CW = $clog2(NUM_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);

    logic [NUM_BITS-1:0] parallel_reg;
    logic [NUM_BITS-1:0] shifted_next;
    logic [CW-1:0]       count_reg;
    logic [NUM_BITS-1:0] word_reg;
    logic                valid_reg;
    logic                overflow_reg;
    logic                complete;

    generate
        if (SHIFT_MSB) begin : g_shift_left
            assign shifted_next = {parallel_reg[NUM_BITS-2:0], serial_in};
        end else begin : g_shift_right
            assign shifted_next = {serial_in, parallel_reg[NUM_BITS-1:1]};
        end
    endgenerate

    // The word completes on the shift that carries the last bit; its value is the post-shift register.
    assign complete = shift_enable && (count_reg == LAST_BIT);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            parallel_reg <= '1;
            count_reg    <= '0;
            word_reg     <= '0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else if (clear) begin
            parallel_reg <= '1;
            count_reg    <= '0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (shift_enable) begin
                parallel_reg <= shifted_next;
                count_reg    <= complete ? '0 : count_reg + 1'b1;
            end
            // A consume on the completing edge frees the holding register for the new word.
            if (complete) begin
                if (!valid_reg || word_ready) begin
                    word_reg  <= shifted_next;
                    valid_reg <= 1'b1;
                end else begin
                    overflow_reg <= 1'b1;
                end
            end else if (valid_reg && word_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign parallel_out = parallel_reg;
    assign bit_count    = count_reg;
    assign word_out     = word_reg;
    assign word_valid   = valid_reg;
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_stp_word_sr.sv
// Bench for stp_word_sr: both shift directions driven in parallel and compared
// against a bit-history reference model; directed scenarios followed by random traffic.
module tb_stp_word_sr;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       clear = 1'b0;
    logic       shift_enable = 1'b0;
    logic       serial_in = 1'b0;
    logic       word_ready = 1'b0;

    logic [7:0] po_m, wo_m, po_l, wo_l;
    logic [2:0] bc_m, bc_l;
    logic       wv_m, ov_m, wv_l, ov_l;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: the last N accepted bits (oldest first), a bit counter and the handshake state.
    bit         hist[$];
    int         cnt;
    logic [7:0] m_word_m, m_word_l;
    bit         m_valid, m_ovf;

    always #5 clk = ~clk;

    stp_word_sr #(.NUM_BITS(N), .SHIFT_MSB(1'b1)) dut_msb (
        .clk(clk), .n_rst(n_rst), .clear(clear), .shift_enable(shift_enable),
        .serial_in(serial_in), .parallel_out(po_m), .bit_count(bc_m),
        .word_out(wo_m), .word_valid(wv_m), .word_ready(word_ready), .overflow(ov_m)
    );

    stp_word_sr #(.NUM_BITS(N), .SHIFT_MSB(1'b0)) dut_lsb (
        .clk(clk), .n_rst(n_rst), .clear(clear), .shift_enable(shift_enable),
        .serial_in(serial_in), .parallel_out(po_l), .bit_count(bc_l),
        .word_out(wo_l), .word_valid(wv_l), .word_ready(word_ready), .overflow(ov_l)
    );

    // First-received bit lands in the MSB when shifting left, in bit 0 when shifting right.
    function automatic logic [7:0] window(bit msb_first);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (msb_first) v[i] = hist[N-1-i];
            else           v[i] = hist[i];
        end
        return v;
    endfunction

    task automatic model_reset(bit full);
        hist = {};
        for (int i = 0; i < N; i++) hist.push_back(1'b1);
        cnt     = 0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        if (full) begin
            m_word_m = 8'h00;
            m_word_l = 8'h00;
        end
    endtask

    task automatic model_step(bit se, bit sin, bit rdy, bit clr);
        bit done;
        done = 1'b0;
        if (clr) begin
            model_reset(1'b0);
        end else begin
            if (se) begin
                hist.push_back(sin);
                void'(hist.pop_front());
                cnt++;
                if (cnt == N) begin
                    cnt  = 0;
                    done = 1'b1;
                end
            end
            if (done) begin
                if (!m_valid || rdy) begin
                    m_word_m = window(1'b1);
                    m_word_l = window(1'b0);
                    m_valid  = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("msb.parallel_out", 32'(po_m), 32'(window(1'b1)));
        chk("msb.bit_count",    32'(bc_m), 32'(cnt));
        chk("msb.word_out",     32'(wo_m), 32'(m_word_m));
        chk("msb.word_valid",   32'(wv_m), 32'(m_valid));
        chk("msb.overflow",     32'(ov_m), 32'(m_ovf));
        chk("lsb.parallel_out", 32'(po_l), 32'(window(1'b0)));
        chk("lsb.bit_count",    32'(bc_l), 32'(cnt));
        chk("lsb.word_out",     32'(wo_l), 32'(m_word_l));
        chk("lsb.word_valid",   32'(wv_l), 32'(m_valid));
        chk("lsb.overflow",     32'(ov_l), 32'(m_ovf));
    endtask

    task automatic step(bit se, bit sin, bit rdy, bit clr);
        @(negedge clk);
        shift_enable = se;
        serial_in    = sin;
        word_ready   = rdy;
        clear        = clr;
        @(posedge clk);
        model_step(se, sin, rdy, clr);
        #1;
        check_all();
    endtask

    // Sends b most-significant bit first; rdy_last applies to the completing bit only.
    task automatic send_byte(logic [7:0] b, bit rdy, bit rdy_last, bit gapped);
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, b[i], (i == 0) ? rdy_last : rdy, 1'b0);
            if (gapped) step(1'b0, 1'b0, rdy, 1'b0);
        end
    endtask

    initial begin
        model_reset(1'b1);

        // Reset values while n_rst is held low across clock edges
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset.parallel_out", 32'(po_m), 32'hFF);
        chk("reset.word_out",     32'(wo_m), 32'h00);
        @(negedge clk);
        n_rst = 1'b1;

        // Direction and gapped enable: 1,1,0,1,0,0,0,0
        send_byte(8'hD0, 1'b0, 1'b0, 1'b1);
        chk("dir.msb_word", 32'(wo_m), 32'hD0);
        chk("dir.lsb_word", 32'(wo_l), 32'h0B);
        chk("dir.valid",    32'(wv_m), 32'h1);
        chk("dir.count",    32'(bc_m), 32'h0);

        // Back-to-back words with the consumer always ready
        send_byte(8'hA5, 1'b1, 1'b1, 1'b0);
        chk("b2b.word0", 32'(wo_m), 32'hA5);
        send_byte(8'h3C, 1'b1, 1'b1, 1'b0);
        chk("b2b.word1", 32'(wo_m), 32'h3C);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("b2b.valid_drop", 32'(wv_m), 32'h0);
        chk("b2b.overflow",   32'(ov_m), 32'h0);

        // Overflow with a stalled consumer
        send_byte(8'h11, 1'b0, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0, 1'b0);
        chk("ovf.word_kept", 32'(wo_m), 32'h11);
        chk("ovf.flag",      32'(ov_m), 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovf.consumed",  32'(wv_m), 32'h0);
        chk("ovf.sticky",    32'(ov_m), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf.cleared",   32'(ov_m), 32'h0);

        // Consume coinciding with completion keeps word_valid high
        send_byte(8'h55, 1'b0, 1'b0, 1'b0);
        chk("simul.first", 32'(wo_m), 32'h55);
        send_byte(8'h66, 1'b0, 1'b1, 1'b0);
        chk("simul.word",     32'(wo_m), 32'h66);
        chk("simul.valid",    32'(wv_m), 32'h1);
        chk("simul.overflow", 32'(ov_m), 32'h0);

        // Mid-word clear together with shift_enable
        for (int i = 0; i < 5; i++) step(1'b1, 1'(i & 1), 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("clr.count",    32'(bc_m), 32'h0);
        chk("clr.parallel", 32'(po_m), 32'hFF);
        chk("clr.word",     32'(wo_m), 32'h66);

        // Mid-word asynchronous reset pulsed between clock edges
        for (int i = 0; i < 5; i++) step(1'b1, 1'(~i & 1), 1'b0, 1'b0);
        @(negedge clk);
        shift_enable = 1'b0;
        #2;
        n_rst = 1'b0;
        model_reset(1'b1);
        #1;
        check_all();
        chk("arst.word",  32'(wo_m), 32'h00);
        chk("arst.count", 32'(bc_l), 32'h0);
        #1;
        n_rst = 1'b1;

        // Random traffic with gapped enable, random ready and occasional clear
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 80) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
